uart_rx_unit: RTL and testbench
===============================

// Module: uart_rx_unit
// PURPOSE
//   Serial-to-parallel UART receiver for the peripheral subsystem: 8N1 framing, LSB first.
//   Oversamples rxd at 16x baud and holds each received byte in a one-entry buffer.
//   Presents the byte to the peripheral register file through a valid/ack handshake.
//   Reports framing and overrun errors alongside the data.
// PARAMETERS
//   CLK_HZ      50_000_000  system clock frequency in Hz
//   BAUD        9600        line rate in bit/s
//   OVERSAMPLE  16          sample ticks per bit; must be 16
//   DIV         CLK_HZ/(BAUD*OVERSAMPLE)  sysclk cycles per tick; integer division, 325 at defaults
// PORTS
//   sysclk     in   1  system clock; all logic is on the rising edge
//   reset      in   1  synchronous reset, active-high
//   rxd        in   1  asynchronous serial input; idle level is 1
//   rx_ack     in   1  one-cycle pulse from the reader; consumes the held byte
//   rx_data    out  8  held byte; valid only while rx_valid=1
//   rx_valid   out  1  holding register is full
//   frame_err  out  1  one-cycle pulse; stop bit was sampled as 0
//   overrun    out  1  sticky; a byte was overwritten before it was acked
//   busy       out  1  FSM is not in IDLE
// BEHAVIOUR
//   Reset (synchronous, active-high):
//     - FSM=IDLE, tick and bit counters=0, synchronizer flops=1.
//     - rx_data=8'h00, rx_valid=0, frame_err=0, overrun=0, busy=0.
//     - Reset asserted mid-frame aborts the frame; no partial byte is loaded.
//   Input and tick generation:
//     - rxd passes through a 2-flop synchronizer; the FSM sees rxs, 2 cycles late.
//     - Prescaler counts 0..DIV-1 and emits tick on wrap.
//     - The prescaler is cleared on the IDLE->START transition so phase aligns to the start edge.
//   FSM states: IDLE, START, DATA, [PARITY], STOP.
//     IDLE:   rxs=0 -> START, tick_cnt=0.
//     START:  at tick_cnt=7 (mid start bit):
//               - rxs=1 -> IDLE (glitch rejected, nothing flagged);
//               - else -> DATA, tick_cnt=0, bit_cnt=0.
//     DATA:   when tick_cnt=15, sample rxs into shift[bit_cnt] (LSB first), bit_cnt++.
//               - After bit 7 -> STOP (or PARITY when the option is enabled).
//     STOP:   at tick_cnt=15 (mid stop bit), go to IDLE:
//               - rxs=1 -> load the byte;
//               - rxs=0 -> frame_err=1 for one cycle, byte discarded, holding register untouched.
//             IDLE is entered mid stop bit, so back-to-back frames are accepted.
//   Holding register and handshake:
//     - Load: rx_data<=shift, rx_valid<=1.
//     - rx_ack while rx_valid=1: rx_valid<=0 and overrun<=0 on the next edge.
//     - rx_ack while rx_valid=0: ignored.
//     - Load while rx_valid=1 with no rx_ack that cycle: byte overwritten, overrun<=1.
//     - Load and rx_ack in the same cycle: the new byte wins, rx_valid stays 1, overrun unchanged.
//   Latency: rx_valid rises 2 (sync) + 1 cycles after the mid-stop-bit tick.
// CONFIGURATION
//   UART_RX_PARITY_EN defined:
//     - Adds the PARITY state between DATA and STOP, sampled at tick_cnt=15.
//     - Even parity over the 8 data bits; a mismatch pulses frame_err and discards the byte.
//     - A frame is 11 bits long.
//   UART_RX_PARITY_EN undefined: pure 8N1, no PARITY state, frame is 10 bits long.
// TESTING
//   1. Defaults (5200 cycles/bit). Send 0x55, 8N1.
//        -> rx_valid=1, rx_data=8'h55, frame_err never asserted.
//   2. Send 0xA3, leave it unacked, then send 0x0F.
//        -> overrun=1, rx_data=8'h0F. Then pulse rx_ack -> rx_valid=0, overrun=0.
//   3. Send 0x3C with stop bit forced to 0.
//        -> one-cycle frame_err pulse, rx_valid stays 0, busy returns to 0.
//   4. Pull rxd low for 2000 cycles, then release.
//        -> FSM returns to IDLE, no flags, rx_valid=0.
//   5. Pulse rx_ack in the same cycle as the load of byte 0x81.
//        -> rx_valid=1, rx_data=8'h81, overrun=0.
//   6. Assert reset at bit 4 of 0xFF, release it, then send 0x12.
//        -> nothing is loaded for the aborted frame, then rx_data=8'h12.
//      With UART_RX_PARITY_EN: 0x12 sent with parity=1 -> frame_err pulse.

Source files
------------

// File: rtl/uart_rx_unit.sv
// uart_rx_unit: 8N1 UART receiver, 16x oversampling, one-entry holding register with
// valid/ack handshake, framing and overrun flags. Define UART_RX_PARITY_EN for 8E1 framing.
module uart_rx_unit #(
   parameter int unsigned CLK_HZ     = 50_000_000,
   parameter int unsigned BAUD       = 9600,
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned DIV        = CLK_HZ / (BAUD * OVERSAMPLE)
) (
   input  logic       sysclk,
   input  logic       reset,
   input  logic       rxd,
   input  logic       rx_ack,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DivW-1:0] DivMax = DivW'(DIV - 1);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop
   } state_e;

   state_e          state_q, state_d;
   logic            rxd_meta_q, rxs_q;
   logic [DivW-1:0] div_q, div_d;
   logic [3:0]      tick_q, tick_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic [7:0]      rx_data_q, rx_data_d;
   logic            rx_valid_q, rx_valid_d;
   logic            frame_err_q, frame_err_d;
   logic            overrun_q, overrun_d;
   logic            tick;
   logic            load;
   logic            drop;
`ifdef UART_RX_PARITY_EN
   logic            par_err_q, par_err_d;
`endif

   // Two-flop synchronizer; idles high so reset never looks like a start edge.
   always_ff @(posedge sysclk) begin
      if (reset) begin
         rxd_meta_q <= 1'b1;
         rxs_q      <= 1'b1;
      end else begin
         rxd_meta_q <= rxd;
         rxs_q      <= rxd_meta_q;
      end
   end

   assign tick = (div_q == DivMax);

   always_comb begin
      state_d = state_q;
      div_d   = tick ? '0 : div_q + DivW'(1);
      tick_d  = tick_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      load    = 1'b0;
      drop    = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_d = par_err_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (!rxs_q) begin
               state_d = StStart;
               tick_d  = '0;
               div_d   = '0;
            end
         end
         StStart: begin
            if (tick) begin
               if (tick_q == 4'd7) begin
                  if (rxs_q) begin
                     state_d = StIdle;
                  end else begin
                     state_d = StData;
                     tick_d  = '0;
                     bit_d   = '0;
                  end
               end else begin
                  tick_d = tick_q + 4'd1;
               end
            end
         end
         StData: begin
            if (tick) begin
               if (tick_q == 4'd15) begin
                  shift_d[bit_q] = rxs_q;
                  bit_d          = bit_q + 3'd1;
                  tick_d         = '0;
                  if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state_d = StParity;
`else
                     state_d = StStop;
`endif
                  end
               end else begin
                  tick_d = tick_q + 4'd1;
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         StParity: begin
            if (tick) begin
               if (tick_q == 4'd15) begin
                  // Even parity: the parity bit must equal the XOR of the data bits.
                  par_err_d = rxs_q ^ (^shift_q);
                  state_d   = StStop;
                  tick_d    = '0;
               end else begin
                  tick_d = tick_q + 4'd1;
               end
            end
         end
`endif
         StStop: begin
            if (tick) begin
               if (tick_q == 4'd15) begin
                  // Leave mid stop bit so a back-to-back start edge is not missed.
                  state_d = StIdle;
                  tick_d  = '0;
`ifdef UART_RX_PARITY_EN
                  if (rxs_q && !par_err_q) begin
                     load = 1'b1;
                  end else begin
                     drop = 1'b1;
                  end
`else
                  if (rxs_q) begin
                     load = 1'b1;
                  end else begin
                     drop = 1'b1;
                  end
`endif
               end else begin
                  tick_d = tick_q + 4'd1;
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // A load beats a same-cycle ack: the fresh byte stays valid and overrun is left alone.
   always_comb begin
      rx_data_d   = rx_data_q;
      rx_valid_d  = rx_valid_q;
      overrun_d   = overrun_q;
      frame_err_d = drop;
      if (load) begin
         rx_data_d  = shift_q;
         rx_valid_d = 1'b1;
         if (rx_valid_q && !rx_ack) begin
            overrun_d = 1'b1;
         end
      end else if (rx_ack && rx_valid_q) begin
         rx_valid_d = 1'b0;
         overrun_d  = 1'b0;
      end
   end

   always_ff @(posedge sysclk) begin
      if (reset) begin
         state_q     <= StIdle;
         div_q       <= '0;
         tick_q      <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         rx_data_q   <= 8'h00;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         div_q       <= div_d;
         tick_q      <= tick_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge sysclk) begin
      if (reset) begin
         par_err_q <= 1'b0;
      end else begin
         par_err_q <= par_err_d;
      end
   end
`endif

   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;
   assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_unit.sv
// Randomized bench for uart_rx_unit: a frame-level model predicts, per clock edge, when each
// frame resolves and what the holding register, flags and busy must show.
module tb_uart_rx_unit;

   localparam int unsigned CLK_HZ = 1_000_000;
   localparam int unsigned BAUD   = 15_625;
   localparam int D      = 4;  // 1_000_000 / (15_625 * 16)
   localparam int BIT    = 16 * D;
`ifdef UART_RX_PARITY_EN
   localparam int NBITS  = 11;
`else
   localparam int NBITS  = 10;
`endif
   // Edges from the start edge of the line to the mid-stop decision, as seen after the sync.
   localparam int DECIDE = 8 * D + BIT * (NBITS - 1);

   logic       sysclk = 1'b0;
   logic       reset  = 1'b1;
   logic       rxd    = 1'b1;
   logic       rx_ack = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   uart_rx_unit #(
      .CLK_HZ (CLK_HZ),
      .BAUD   (BAUD)
   ) dut (
      .sysclk    (sysclk),
      .reset     (reset),
      .rxd       (rxd),
      .rx_ack    (rx_ack),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .frame_err (frame_err),
      .overrun   (overrun),
      .busy      (busy)
   );

   always #5 sysclk = ~sysclk;

   int n_vec = 0;
   int n_bad = 0;
   int cyc = 0;
   int fe_seen = 0;
   int ack_pm = 0;
   int force_ack_edge = -1;

   logic       m_valid = 1'b0;
   logic [7:0] m_data = 8'h00;
   logic       m_ovr = 1'b0;
   logic       m_fe = 1'b0;
   logic       m_busy = 1'b0;
   int         pend_edge = -1;
   logic       pend_good = 1'b0;
   logic [7:0] pend_data = 8'h00;
   int         busy_from = 0, busy_to = 0;
   int         busy2_from = 0, busy2_to = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model: advances once per rising edge using the inputs the DUT samples on that edge.
   initial forever begin
      @(posedge sysclk);
      cyc++;
      if (reset) begin
         m_valid   = 1'b0;
         m_data    = 8'h00;
         m_ovr     = 1'b0;
         m_fe      = 1'b0;
         pend_edge = -1;
         busy_to   = 0;
         busy2_to  = 0;
      end else begin
         m_fe = 1'b0;
         if (cyc == pend_edge) begin
            pend_edge = -1;
            if (pend_good) begin
               if (m_valid && !rx_ack) m_ovr = 1'b1;
               m_valid = 1'b1;
               m_data  = pend_data;
            end else begin
               m_fe = 1'b1;
               if (rx_ack && m_valid) begin
                  m_valid = 1'b0;
                  m_ovr   = 1'b0;
               end
            end
         end else if (rx_ack && m_valid) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
         end
      end
      m_busy = (cyc >= busy_from && cyc < busy_to) || (cyc >= busy2_from && cyc < busy2_to);
   end

   // Compare: every cycle, away from the active edge.
   initial forever begin
      @(negedge sysclk);
      if (cyc > 0) begin
         check("busy", 32'(busy), 32'(m_busy));
         check("rx_valid", 32'(rx_valid), 32'(m_valid));
         check("frame_err", 32'(frame_err), 32'(m_fe));
         check("overrun", 32'(overrun), 32'(m_ovr));
         if (m_valid) check("rx_data", 32'(rx_data), 32'(m_data));
         if (frame_err === 1'b1) fe_seen++;
      end
   end

   task automatic step();
      @(negedge sysclk);
      rx_ack = ((cyc + 1) == force_ack_edge) || ($urandom_range(999, 0) < ack_pm);
   endtask

   task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic par_flip,
                             input bit ack_at_load, input int abort_bit);
      logic [10:0] bits;
      int k, decide;
      bits    = '1;
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[i+1] = data[i];
`ifdef UART_RX_PARITY_EN
      bits[9]  = (^data) ^ par_flip;
      bits[10] = stop_bit;
`else
      bits[9]  = stop_bit;
`endif
      step();
      k         = cyc + 1;
      decide    = k + 2 + DECIDE;
      busy_from = k + 2;
      busy_to   = decide;
      pend_edge = decide;
      pend_good = stop_bit && !par_flip;
      pend_data = data;
      force_ack_edge = ack_at_load ? decide : -1;
      // A low stop bit leaves the line low past the decision: a short false start follows.
      if (!stop_bit) begin
         busy2_from = decide + 1;
         busy2_to   = decide + 1 + 8 * D;
      end
      for (int b = 0; b < NBITS; b++) begin
         if (b == abort_bit) begin
            rxd   = 1'b1;
            reset = 1'b1;
            force_ack_edge = -1;
            repeat (3) step();
            reset = 1'b0;
            repeat (4) step();
            return;
         end
         rxd = bits[b];
         if (b == NBITS - 1 && !stop_bit) begin
            repeat (12 * D) step();
            rxd = 1'b1;
            repeat (4 * D) step();
         end else begin
            repeat (BIT) step();
         end
      end
      rxd = 1'b1;
   endtask

   task automatic glitch(input int len);
      int k;
      step();
      k         = cyc + 1;
      busy_from = k + 2;
      busy_to   = k + 2 + 8 * D;
      rxd       = 1'b0;
      repeat (len) step();
      rxd = 1'b1;
      repeat (8 * D + 4) step();
   endtask

   task automatic pulse_ack();
      step();
      rx_ack = 1'b1;
      step();
   endtask

   initial begin
      #950_000;
      $display("FAIL watchdog: got no finish, expected finish by 95000 cycles");
      $fatal(1, "watchdog");
   end

   initial begin
      int fe0;
      logic [7:0] d;
      logic sb, pf;
      repeat (3) step();
      check("reset rx_valid", 32'(rx_valid), 32'h0);
      check("reset rx_data", 32'(rx_data), 32'h00);
      check("reset busy", 32'(busy), 32'h0);
      check("reset overrun", 32'(overrun), 32'h0);
      check("reset frame_err", 32'(frame_err), 32'h0);
      reset = 1'b0;
      repeat (5) step();

      fe0 = fe_seen;
      send_frame(8'h55, 1'b1, 1'b0, 1'b0, -1);
      check("t1 rx_valid", 32'(rx_valid), 32'h1);
      check("t1 rx_data", 32'(rx_data), 32'h55);
      check("t1 frame_err count", 32'(fe_seen - fe0), 32'h0);
      pulse_ack();

      send_frame(8'hA3, 1'b1, 1'b0, 1'b0, -1);
      repeat (3) step();
      send_frame(8'h0F, 1'b1, 1'b0, 1'b0, -1);
      check("t2 overrun", 32'(overrun), 32'h1);
      check("t2 rx_data", 32'(rx_data), 32'h0F);
      pulse_ack();
      check("t2 ack rx_valid", 32'(rx_valid), 32'h0);
      check("t2 ack overrun", 32'(overrun), 32'h0);

      fe0 = fe_seen;
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0, -1);
      repeat (8) step();
      check("t3 frame_err count", 32'(fe_seen - fe0), 32'h1);
      check("t3 rx_valid", 32'(rx_valid), 32'h0);
      check("t3 busy", 32'(busy), 32'h0);

      fe0 = fe_seen;
      glitch(20);
      check("t4 rx_valid", 32'(rx_valid), 32'h0);
      check("t4 busy", 32'(busy), 32'h0);
      check("t4 frame_err count", 32'(fe_seen - fe0), 32'h0);

      send_frame(8'h81, 1'b1, 1'b0, 1'b1, -1);
      check("t5 rx_valid", 32'(rx_valid), 32'h1);
      check("t5 rx_data", 32'(rx_data), 32'h81);
      check("t5 overrun", 32'(overrun), 32'h0);

      send_frame(8'hFF, 1'b1, 1'b0, 1'b0, 5);
      check("t6 abort rx_valid", 32'(rx_valid), 32'h0);
      check("t6 abort busy", 32'(busy), 32'h0);
      fe0 = fe_seen;
      send_frame(8'h12, 1'b1, 1'b0, 1'b0, -1);
      check("t6 rx_valid", 32'(rx_valid), 32'h1);
      check("t6 rx_data", 32'(rx_data), 32'h12);
      check("t6 frame_err count", 32'(fe_seen - fe0), 32'h0);
`ifdef UART_RX_PARITY_EN
      pulse_ack();
      fe0 = fe_seen;
      send_frame(8'h12, 1'b1, 1'b1, 1'b0, -1);
      check("t6 parity frame_err count", 32'(fe_seen - fe0), 32'h1);
      check("t6 parity rx_valid", 32'(rx_valid), 32'h0);
`endif

      ack_pm = 3;
      for (int i = 0; i < 40; i++) begin
         int r;
         r = int'($urandom_range(99, 0));
         if (r < 8) begin
            glitch(int'($urandom_range(8 * D - 2, 2)));
         end else if (r < 13) begin
            send_frame(8'($urandom), 1'b1, 1'b0, 1'b0, int'($urandom_range(NBITS - 1, 1)));
         end else begin
            d  = 8'($urandom);
            sb = ($urandom_range(9, 0) != 0);
`ifdef UART_RX_PARITY_EN
            pf = ($urandom_range(9, 0) == 0);
`else
            pf = 1'b0;
`endif
            send_frame(d, sb, pf, ($urandom_range(7, 0) == 0), -1);
         end
         repeat (int'($urandom_range(12, 0))) step();
      end
      ack_pm = 0;
      repeat (20) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
